// File: rtl/cam_pkg.sv
// Shared opcodes and sequencer state encoding for the CAM subarray command path.
package cam_pkg;

  localparam logic [2:0] OP_WRITE   = 3'b000;
  localparam logic [2:0] OP_UPDATE  = 3'b001;
  localparam logic [2:0] OP_S_CMP   = 3'b010;
  localparam logic [2:0] OP_S_PPG   = 3'b011;
  localparam logic [2:0] OP_S_CMP2  = 3'b100;
  localparam logic [2:0] OP_S_PPG2  = 3'b101;
  localparam logic [2:0] OP_S_MIX   = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_t;

  function automatic logic is_search(input logic [2:0] op);
    return (op >= OP_S_CMP) && (op <= OP_S_MIX);
  endfunction

endpackage

// File: rtl/cam_rsp_slice.sv
// Response holding register: keeps rsp_tag/rsp_err stable from load until the
// consumer takes the response.
module cam_rsp_slice #(
  parameter int TAG_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             load_err,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rsp_valid <= 1'b0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_tag   <= load_tag;
      rsp_err   <= load_err;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_op_sequencer.sv
// Single-owner command sequencer for a 36x32 CAM subarray: issues one control
// pulse per command, waits out search latency and returns (optionally chained) results.
module cam_op_sequencer
  import cam_pkg::*;
#(
  parameter int TAG_W   = 32,
  parameter int TAG_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_chain,
  input  logic [TAG_W-1:0] cmd_data,
  input  logic [TAG_W-1:0] cmd_mask,
  input  logic             cmd_update,
  input  logic [9:0]       cmd_cmp_addr,
  input  logic [5:0]       cmd_ppg_addr,
  input  logic [1:0]       cmd_cmp_data,
  input  logic [1:0]       cmd_ppg_data,
  input  logic             cmd_addr_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [TAG_W-1:0] cam_data_in,
  output logic             cam_update_signal,
  output logic [9:0]       cam_cmp_addr,
  output logic [5:0]       cam_ppg_addr,
  output logic [1:0]       cam_cmp_data,
  output logic [1:0]       cam_ppg_data,
  output logic [TAG_W-1:0] cam_tag_in,
  output logic             cam_addr_select,
  output logic [2:0]       cam_operation_mode,
  output logic             cam_chip_enable,
  input  logic [TAG_W-1:0] cam_tag_out
);

  seq_state_t       state;
  logic [2:0]       op_q;
  logic             chain_q;
  logic [2:0]       wait_cnt;
  logic [TAG_W-1:0] acc;
  logic [TAG_W-1:0] result_tag;
  logic             result_err;
  logic             rsp_load;
  logic [TAG_W-1:0] search_result;

  assign cmd_ready     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign search_result = chain_q ? (acc & cam_tag_out) : cam_tag_out;

  // cam_* pins are loaded on the accepting edge so they are valid for the whole
  // ISSUE cycle and otherwise hold, keeping the subarray inputs glitch-free.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state              <= ST_IDLE;
      op_q               <= '0;
      chain_q            <= 1'b0;
      wait_cnt           <= '0;
      acc                <= '1;
      result_tag         <= '0;
      result_err         <= 1'b0;
      rsp_load           <= 1'b0;
      cam_data_in        <= '0;
      cam_update_signal  <= 1'b0;
      cam_cmp_addr       <= '0;
      cam_ppg_addr       <= '0;
      cam_cmp_data       <= '0;
      cam_ppg_data       <= '0;
      cam_tag_in         <= '0;
      cam_addr_select    <= 1'b0;
      cam_operation_mode <= '0;
      cam_chip_enable    <= 1'b0;
    end else begin
      rsp_load        <= 1'b0;
      cam_chip_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            chain_q <= cmd_chain;
            state   <= ST_ISSUE;
            if (cmd_op != OP_ILLEGAL) begin
              cam_chip_enable    <= 1'b1;
              cam_operation_mode <= cmd_op;
              cam_update_signal  <= (cmd_op == OP_UPDATE) && cmd_update;
              cam_cmp_addr       <= cmd_cmp_addr;
              cam_ppg_addr       <= cmd_ppg_addr;
              cam_cmp_data       <= cmd_cmp_data;
              cam_ppg_data       <= cmd_ppg_data;
              cam_addr_select    <= cmd_addr_sel;
              if (cmd_op == OP_WRITE)
                cam_data_in <= cmd_data;
              if (cmd_op == OP_UPDATE)
                cam_tag_in <= cmd_mask;
              else if (is_search(cmd_op))
                cam_tag_in <= acc;
            end
          end
        end
        ST_ISSUE: begin
          if (op_q == OP_ILLEGAL) begin
            result_tag <= '0;
            result_err <= 1'b1;
            rsp_load   <= 1'b1;
            state      <= ST_RESP;
          end else if (is_search(op_q)) begin
            wait_cnt <= 3'(TAG_LAT - 1);
            state    <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            acc        <= search_result;
            result_tag <= search_result;
            result_err <= 1'b0;
            rsp_load   <= 1'b1;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_valid && rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cam_rsp_slice #(
    .TAG_W(TAG_W)
  ) u_rsp_slice (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (rsp_load),
    .load_tag  (result_tag),
    .load_err  (result_err),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err)
  );

endmodule

// File: tb/tb_cam_op_sequencer.sv
// Self-checking bench for cam_op_sequencer: directed vector table, reset corner
// cases and randomized commands against a behavioural accumulator model.
module tb_cam_op_sequencer;

  localparam int TAG_LAT = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic        cmd_chain = 1'b0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_mask = '0;
  logic        cmd_update = 1'b0;
  logic [9:0]  cmd_cmp_addr = '0;
  logic [5:0]  cmd_ppg_addr = '0;
  logic [1:0]  cmd_cmp_data = '0;
  logic [1:0]  cmd_ppg_data = '0;
  logic        cmd_addr_sel = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_tag;
  logic        rsp_err;
  logic        busy;
  logic [31:0] cam_data_in;
  logic        cam_update_signal;
  logic [9:0]  cam_cmp_addr;
  logic [5:0]  cam_ppg_addr;
  logic [1:0]  cam_cmp_data;
  logic [1:0]  cam_ppg_data;
  logic [31:0] cam_tag_in;
  logic        cam_addr_select;
  logic [2:0]  cam_operation_mode;
  logic        cam_chip_enable;
  logic [31:0] cam_tag_out = '0;

  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] acc_m = 32'hFFFF_FFFF;

  typedef struct {
    logic [2:0]  op;
    logic        chain;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] tag;
    logic [9:0]  cmp_addr;
    logic        addr_sel;
    int          stall;
    logic        exp_rsp;
    logic [31:0] exp_tag;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  cam_op_sequencer #(.TAG_W(32), .TAG_LAT(TAG_LAT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_update(cmd_update),
    .cmd_cmp_addr(cmd_cmp_addr), .cmd_ppg_addr(cmd_ppg_addr), .cmd_cmp_data(cmd_cmp_data),
    .cmd_ppg_data(cmd_ppg_data), .cmd_addr_sel(cmd_addr_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy),
    .cam_data_in(cam_data_in), .cam_update_signal(cam_update_signal),
    .cam_cmp_addr(cam_cmp_addr), .cam_ppg_addr(cam_ppg_addr),
    .cam_cmp_data(cam_cmp_data), .cam_ppg_data(cam_ppg_data),
    .cam_tag_in(cam_tag_in), .cam_addr_select(cam_addr_select),
    .cam_operation_mode(cam_operation_mode), .cam_chip_enable(cam_chip_enable),
    .cam_tag_out(cam_tag_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output bit ok);
    @(negedge CLK);
    cmd_op       = v.op;
    cmd_chain    = v.chain;
    cmd_data     = v.data;
    cmd_mask     = v.mask;
    cmd_update   = 1'b1;
    cmd_cmp_addr = v.cmp_addr;
    cmd_ppg_addr = v.cmp_addr[5:0];
    cmd_cmp_data = v.cmp_addr[1:0];
    cmd_ppg_data = v.cmp_addr[3:2];
    cmd_addr_sel = v.addr_sel;
    cam_tag_out  = v.tag;
    cmd_valid    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    checkOutput("handshake", 32'(ok), 32'd1);
  endtask

  task automatic runCmd(input vec_t v);
    bit   ok;
    logic is_s;
    int   lat;
    logic [31:0] held;
    applyStimulus(v, ok);
    if (!ok) return;
    is_s = (v.op >= 3'd2) && (v.op <= 3'd6);
    @(negedge CLK);
    checkOutput("chip_enable_issue", 32'(cam_chip_enable), 32'(v.op != 3'd7));
    if (v.op != 3'd7) begin
      checkOutput("op_mode", 32'(cam_operation_mode), 32'(v.op));
      checkOutput("cmp_addr", 32'(cam_cmp_addr), 32'(v.cmp_addr));
      checkOutput("ppg_addr", 32'(cam_ppg_addr), 32'(v.cmp_addr[5:0]));
      checkOutput("addr_select", 32'(cam_addr_select), 32'(v.addr_sel));
    end
    if (v.op == 3'd0) checkOutput("data_in", cam_data_in, v.data);
    if (v.op == 3'd1) begin
      checkOutput("tag_in_mask", cam_tag_in, v.mask);
      checkOutput("update_signal", 32'(cam_update_signal), 32'd1);
    end
    if (is_s) begin
      checkOutput("tag_in_acc", cam_tag_in, acc_m);
      acc_m = v.chain ? (acc_m & v.tag) : v.tag;
    end
    if (!v.exp_rsp) begin
      @(negedge CLK);
      checkOutput("ce_after_issue", 32'(cam_chip_enable), 32'd0);
      checkOutput("ready_after_wr", 32'(cmd_ready), 32'd1);
      checkOutput("no_rsp", 32'(rsp_valid), 32'd0);
      return;
    end
    lat = (v.op == 3'd7) ? 2 : 2 + TAG_LAT;
    for (int k = 1; k < lat; k++) begin
      @(negedge CLK);
      checkOutput("rsp_early", 32'(rsp_valid), 32'd0);
      checkOutput("ce_wait", 32'(cam_chip_enable), 32'd0);
    end
    @(negedge CLK);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_tag", rsp_tag, v.exp_tag);
    checkOutput("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    checkOutput("ready_in_resp", 32'(cmd_ready), 32'd0);
    held = rsp_tag;
    cmd_op = 3'd0;
    cmd_data = 32'h1357_9BDF;
    cmd_valid = (v.stall > 0);
    for (int s = 0; s < v.stall; s++) begin
      @(negedge CLK);
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_tag", rsp_tag, held);
      checkOutput("stall_ready", 32'(cmd_ready), 32'd0);
      checkOutput("stall_ce", 32'(cam_chip_enable), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    checkOutput("rsp_drop", 32'(rsp_valid), 32'd0);
    checkOutput("idle_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    bit   ok;
    tbl[0] = '{3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 10'd0, 1'b1, 0, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{3'd1, 1'b0, 32'h0, 32'hA5A5_0000, 32'h0, 10'd5, 1'b0, 0, 1'b0, 32'h0, 1'b0};
    tbl[2] = '{3'd2, 1'b0, 32'h0, 32'h0, 32'h0000_00F0, 10'b00001_00000, 1'b0, 0, 1'b1, 32'h0000_00F0, 1'b0};
    tbl[3] = '{3'd3, 1'b0, 32'h0, 32'h0, 32'h0F0F_0F0F, 10'd7, 1'b0, 0, 1'b1, 32'h0F0F_0F0F, 1'b0};
    tbl[4] = '{3'd4, 1'b1, 32'h0, 32'h0, 32'h00FF_00FF, 10'd9, 1'b1, 5, 1'b1, 32'h000F_000F, 1'b0};
    tbl[5] = '{3'd7, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 10'd3, 1'b0, 1, 1'b1, 32'h0, 1'b1};
    tbl[6] = '{3'd5, 1'b1, 32'h0, 32'h0, 32'h0000_FFFF, 10'd11, 1'b0, 0, 1'b1, 32'h0000_000F, 1'b0};
    tbl[7] = '{3'd6, 1'b0, 32'h0, 32'h0, 32'hCAFE_BABE, 10'd1023, 1'b1, 2, 1'b1, 32'hCAFE_BABE, 1'b0};

    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_ce", 32'(cam_chip_enable), 32'd0);
    checkOutput("reset_rsp_tag", rsp_tag, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_data_in", cam_data_in, 32'd0);

    for (int i = 0; i < 8; i++) runCmd(tbl[i]);

    // Reset while a search sits in WAIT: no response, acc back to all-ones.
    v = '{3'd3, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 10'd2, 1'b0, 0, 1'b1, 32'h0, 1'b0};
    applyStimulus(v, ok);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("in_wait_busy", 32'(busy), 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_mode", 32'(cam_operation_mode), 32'd0);
    checkOutput("midreset_tag_in", cam_tag_in, 32'd0);
    RST_N = 1'b1;
    acc_m = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("midreset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    v = '{3'd2, 1'b1, 32'h0, 32'h0, 32'h1234_5678, 10'd4, 1'b0, 0, 1'b1, 32'h1234_5678, 1'b0};
    runCmd(v);

    for (int i = 0; i < 30; i++) begin
      v.op       = 3'($urandom_range(0, 7));
      v.chain    = 1'($urandom_range(0, 1));
      v.data     = $urandom;
      v.mask     = $urandom;
      v.tag      = $urandom;
      v.cmp_addr = 10'($urandom);
      v.addr_sel = 1'($urandom_range(0, 1));
      v.stall    = $urandom_range(0, 2);
      v.exp_rsp  = (v.op >= 3'd2);
      v.exp_err  = (v.op == 3'd7);
      if (v.op == 3'd7) v.exp_tag = 32'h0;
      else if (v.chain) v.exp_tag = acc_m & v.tag;
      else v.exp_tag = v.tag;
      runCmd(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
